// File: rtl/ddr_iod_lane_delay_ctrl.sv
// Delay-line controller for a group of DDR3 command/address IOD lanes: turns tap requests into
// LOAD/MOVE/DIRECTION pulse sequences and stages TX/OE data. Optional: DDR_IOD_LANE_QUIET_EN.
module ddr_iod_lane_delay_ctrl #(
    parameter int unsigned NUM_LANES     = 4,
    parameter int unsigned TAP_W         = 8,
    parameter int unsigned MAX_TAP       = 255,
    parameter int unsigned INIT_TAP      = 1,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned LANE_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                       FAB_CLK,
    input  logic                       ARST,
    input  logic [4*NUM_LANES-1:0]     TX_DATA_IN,
    input  logic [4*NUM_LANES-1:0]     OE_DATA_IN,
    output logic [4*NUM_LANES-1:0]     TX_DATA,
    output logic [4*NUM_LANES-1:0]     OE_DATA,
    output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
    input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
    input  logic                       REQ_VALID,
    output logic                       REQ_READY,
    input  logic [LANE_W-1:0]          REQ_LANE,
    input  logic [TAP_W-1:0]           REQ_TAP,
    input  logic                       REQ_LOAD,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       ERR,
    output logic [TAP_W*NUM_LANES-1:0] CUR_TAP
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] InitTap = TAP_W'(INIT_TAP);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLoad   = 3'd1;
    localparam logic [2:0] StSettle = 3'd2;
    localparam logic [2:0] StCmp    = 3'd3;
    localparam logic [2:0] StMove   = 3'd4;
    localparam logic [2:0] StFin    = 3'd5;

    logic [2:0]                          state_q, state_d;
    logic [LANE_W-1:0]                   lane_q, lane_d;
    logic [TAP_W-1:0]                    tgt_q, tgt_d;
    logic                                err_q, err_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [NUM_LANES-1:0]                dir_q, dir_d;
    logic [NUM_LANES-1:0][TAP_W-1:0]     cur_q, cur_d;
    logic [4*NUM_LANES-1:0]              tx_q, tx_d;
    logic [4*NUM_LANES-1:0]              oe_q, oe_d;

    logic [NUM_LANES-1:0] lane_oh;
    logic [NUM_LANES-1:0] req_oh;
    logic [TAP_W-1:0]     cur_sel;
    logic                 oor_sel;
    logic                 req_bad;

    always_comb begin
        lane_oh = '0;
        req_oh  = '0;
        cur_sel = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_oh[i] = (lane_q == LANE_W'(i));
            req_oh[i]  = (REQ_LANE == LANE_W'(i));
            if (lane_q == LANE_W'(i)) begin
                cur_sel = cur_q[i];
            end
        end
        oor_sel = |(DELAY_LINE_OUT_OF_RANGE & lane_oh);
        req_bad = (32'(REQ_LANE) >= NUM_LANES) || (32'(REQ_TAP) > MAX_TAP);
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        tgt_d   = tgt_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        cur_d   = cur_q;
        unique case (state_q)
            StIdle: begin
                if (REQ_VALID) begin
                    lane_d = REQ_LANE;
                    tgt_d  = REQ_TAP;
                    err_d  = 1'b0;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else if (REQ_LOAD) begin
                        // Tap tracking follows the pulse so CUR_TAP is current while LOAD is high.
                        for (int i = 0; i < NUM_LANES; i++) begin
                            if (req_oh[i]) cur_d[i] = InitTap;
                        end
                        state_d = StLoad;
                    end else begin
                        state_d = StCmp;
                    end
                end
            end
            StLoad: begin
                cnt_d   = CntLoad;
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    if (oor_sel) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        state_d = StCmp;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StCmp: begin
                if (cur_sel == tgt_q) begin
                    state_d = StFin;
                end else begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (lane_oh[i]) begin
                            dir_d[i] = (tgt_q > cur_sel);
                            cur_d[i] = (tgt_q > cur_sel) ? cur_sel + TAP_W'(1)
                                                         : cur_sel - TAP_W'(1);
                        end
                    end
                    state_d = StMove;
                end
            end
            StMove: begin
                cnt_d   = CntLoad;
                state_d = StSettle;
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        tx_d = TX_DATA_IN;
        oe_d = OE_DATA_IN;
`ifdef DDR_IOD_LANE_QUIET_EN
        // Quiet the lane under adjustment from its pulse through the end of settling.
        if (state_d == StLoad || state_d == StMove || state_d == StSettle) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_d == LANE_W'(i)) begin
                    tx_d[4*i +: 4] = tx_q[4*i +: 4];
                    oe_d[4*i +: 4] = 4'b0000;
                end
            end
        end
`endif
    end

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            state_q <= StIdle;
            lane_q  <= '0;
            tgt_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= '0;
            cur_q   <= {NUM_LANES{InitTap}};
            tx_q    <= '0;
            oe_q    <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            tgt_q   <= tgt_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            cur_q   <= cur_d;
            tx_q    <= tx_d;
            oe_q    <= oe_d;
        end
    end

    always_comb begin
        REQ_READY            = (state_q == StIdle) && !ARST;
        BUSY                 = (state_q != StIdle);
        DONE                 = (state_q == StFin);
        ERR                  = (state_q == StFin) && err_q;
        DELAY_LINE_LOAD      = (state_q == StLoad) ? lane_oh : '0;
        DELAY_LINE_MOVE      = (state_q == StMove) ? lane_oh : '0;
        DELAY_LINE_DIRECTION = dir_d;
        CUR_TAP              = cur_q;
        TX_DATA              = tx_q;
        OE_DATA              = oe_q;
    end

endmodule

// File: tb/tb_ddr_iod_lane_delay_ctrl.sv
// Scoreboard bench for ddr_iod_lane_delay_ctrl: directed tap requests with hand-computed
// completion cycles, pulse counts and final taps; data path checked every cycle.
module tb_ddr_iod_lane_delay_ctrl;

    localparam int NL = 4;
    localparam int TW = 9;
    localparam int LW = 3;
    localparam int S  = 4;

    logic              FAB_CLK = 1'b0;
    logic              ARST    = 1'b1;
    logic [4*NL-1:0]   TX_DATA_IN, OE_DATA_IN, TX_DATA, OE_DATA;
    logic [NL-1:0]     LD, MV, DIR, OOR;
    logic              REQ_VALID, REQ_READY, REQ_LOAD, BUSY, DONE, ERR;
    logic [LW-1:0]     REQ_LANE;
    logic [TW-1:0]     REQ_TAP;
    logic [TW*NL-1:0]  CUR_TAP;

    ddr_iod_lane_delay_ctrl #(
        .NUM_LANES(NL), .TAP_W(TW), .MAX_TAP(255), .INIT_TAP(1), .SETTLE_CYCLES(S), .LANE_W(LW)
    ) dut (
        .FAB_CLK(FAB_CLK), .ARST(ARST),
        .TX_DATA_IN(TX_DATA_IN), .OE_DATA_IN(OE_DATA_IN),
        .TX_DATA(TX_DATA), .OE_DATA(OE_DATA),
        .DELAY_LINE_LOAD(LD), .DELAY_LINE_MOVE(MV), .DELAY_LINE_DIRECTION(DIR),
        .DELAY_LINE_OUT_OF_RANGE(OOR),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_LANE(REQ_LANE),
        .REQ_TAP(REQ_TAP), .REQ_LOAD(REQ_LOAD),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CUR_TAP(CUR_TAP)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    typedef struct {
        int lane;
        int tap;
        bit err;
        int done_edge;
        int moves;
        int loads;
        bit dir;
        bit chk_tap;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edges   = 0;
    bit   abort_mode = 1'b0;

    always @(posedge FAB_CLK) edges <= edges + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
                     name, act, act, exp, exp, edges);
        end
    endtask

    // Monitor: counts pulses of the in-flight request and checks the response at DONE.
    int         mv_cnt = 0;
    int         ld_cnt = 0;
    exp_t       e;
    logic [NL-1:0] oh;
    always @(negedge FAB_CLK) begin
        if (ARST) begin
            mv_cnt = 0;
            ld_cnt = 0;
        end else begin
            if ((MV | LD) != '0) begin
                if (sb.size() == 0) begin
                    if (!abort_mode) chk("stray_pulse", {MV, LD}, 0);
                end else begin
                    oh = (sb[0].lane < NL) ? NL'(1 << sb[0].lane) : '0;
                    chk("pulse_lane", (MV | LD) & ~oh, 0);
                    if ((MV & oh) != '0) begin
                        mv_cnt++;
                        chk("direction", DIR[sb[0].lane], sb[0].dir);
                    end
                    if ((LD & oh) != '0) ld_cnt++;
                end
            end
            if (DONE) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", DONE, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", edges, e.done_edge);
                    chk("err", ERR, e.err);
                    chk("move_count", mv_cnt, e.moves);
                    chk("load_count", ld_cnt, e.loads);
                    if (e.chk_tap) chk("cur_tap", CUR_TAP[e.lane*TW +: TW], e.tap);
                end
                mv_cnt = 0;
                ld_cnt = 0;
            end
        end
    end

    // Data path: outputs must equal the inputs driven one cycle earlier.
    logic [4*NL-1:0] tx_prev, oe_prev;
    bit              dp_ok = 1'b0;
    always @(negedge FAB_CLK) begin
        if (ARST) begin
            dp_ok = 1'b0;
        end else begin
            if (dp_ok) begin
`ifndef DDR_IOD_LANE_QUIET_EN
                chk("tx_data", TX_DATA, tx_prev);
                chk("oe_data", OE_DATA, oe_prev);
`else
                for (int i = 0; i < NL; i++) begin
                    if (LD[i] || MV[i]) chk("oe_quiet", OE_DATA[4*i +: 4], 0);
                end
`endif
            end
            TX_DATA_IN = 16'hA5C3 ^ 16'(edges * 16'h1357);
            OE_DATA_IN = 16'h3C69 + 16'(edges * 16'h0F1D);
            tx_prev    = TX_DATA_IN;
            oe_prev    = OE_DATA_IN;
            dp_ok      = 1'b1;
        end
    end

    task automatic issue(input int lane, input int tap, input bit ld, input int rel,
                         input bit err, input int exp_tap, input int mv, input int nld,
                         input bit dir, input bit chk_tap, input bit push);
        exp_t x;
        bit   acc = 1'b0;
        @(negedge FAB_CLK);
        REQ_VALID = 1'b1;
        REQ_LANE  = LW'(lane);
        REQ_TAP   = TW'(tap);
        REQ_LOAD  = ld;
        for (int k = 0; k < 200 && !acc; k++) begin
            if (REQ_READY) begin
                if (push) begin
                    x.lane = lane; x.tap = exp_tap; x.err = err; x.done_edge = edges + rel;
                    x.moves = mv; x.loads = nld; x.dir = dir; x.chk_tap = chk_tap;
                    sb.push_back(x);
                end
                acc = 1'b1;
                @(posedge FAB_CLK);
                #1;
                // Scramble the request bus to show the fields were captured.
                REQ_VALID = 1'b0;
                REQ_LANE  = '1;
                REQ_TAP   = '1;
                REQ_LOAD  = ~ld;
            end else begin
                @(negedge FAB_CLK);
            end
        end
        if (!acc) chk("accept_timeout", acc, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge FAB_CLK);
            if (!BUSY && sb.size() == 0) ok = 1'b1;
        end
        chk("idle_timeout", ok, 1);
    endtask

    initial begin
        bit seen;
        REQ_VALID = 1'b0; REQ_LANE = '0; REQ_TAP = '0; REQ_LOAD = 1'b0; OOR = '0;
        TX_DATA_IN = '0; OE_DATA_IN = '0;
        repeat (2) @(negedge FAB_CLK);
        chk("rst_ready", REQ_READY, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", {DONE, ERR}, 0);
        chk("rst_pulses", {LD, MV, DIR}, 0);
        chk("rst_data", {TX_DATA, OE_DATA}, 0);
        chk("rst_cur_tap", CUR_TAP, {NL{9'd1}});
        #2 ARST = 1'b0;
        @(negedge FAB_CLK);
        chk("ready_after_rst", REQ_READY, 1);

        //    lane tap ld rel err etap mv ld dir chk push
        issue(2,   4,  0, 20, 0,  4,   3, 0, 1,  1,  1);
        issue(0,   0,  1, 13, 0,  0,   1, 1, 0,  1,  1);
        wait_idle();
        OOR[1] = 1'b1;
        issue(1,   3,  0,  7, 1,  2,   1, 0, 1,  1,  1);
        wait_idle();
        OOR = '0;
        issue(5,   3,  0,  1, 1,  0,   0, 0, 0,  0,  1);
        issue(1, 300,  0,  1, 1,  2,   0, 0, 0,  1,  1);
        issue(3,   1,  0,  2, 0,  1,   0, 0, 0,  1,  1);
        issue(2,   1,  1,  7, 0,  1,   0, 1, 0,  1,  1);
        issue(3,   2,  0,  8, 0,  2,   1, 0, 1,  1,  1);
        wait_idle();

        // Reset in the middle of a MOVE pulse: everything returns to reset values, no DONE.
        abort_mode = 1'b1;
        issue(3, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge FAB_CLK);
            if (MV[3]) seen = 1'b1;
        end
        chk("move_seen", seen, 1);
        #1 ARST = 1'b1;
        #1;
        chk("abort_pulses", {LD, MV, DIR}, 0);
        chk("abort_status", {BUSY, DONE, ERR, REQ_READY}, 0);
        chk("abort_data", {TX_DATA, OE_DATA}, 0);
        chk("abort_cur_tap", CUR_TAP, {NL{9'd1}});
        @(negedge FAB_CLK);
        @(negedge FAB_CLK);
        #2 ARST = 1'b0;
        abort_mode = 1'b0;
        repeat (30) @(negedge FAB_CLK);
        chk("ready_after_abort", REQ_READY, 1);
        issue(0,   1,  0,  2, 0,  1,   0, 0, 0,  1,  1);
        wait_idle();
        chk("leftover_expected", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
